// File: rtl/csr_exec_unit_pkg.sv
// rtl/csr_exec_unit_pkg.sv - shared constants for the execute stage and its CSR file
package csr_exec_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] MSTATUS_RST = 32'h0000_1800;

  localparam logic [2:0] SEL_RS1_RS2 = 3'd0;
  localparam logic [2:0] SEL_RS1_IMM = 3'd1;
  localparam logic [2:0] SEL_PC_4    = 3'd2;
  localparam logic [2:0] SEL_PC_IMM  = 3'd3;
  localparam logic [2:0] SEL_0_IMM   = 3'd4;
  localparam logic [2:0] SEL_RS1_CSR = 3'd5;

  localparam logic [4:0] OPT_ADD   = 5'd0;
  localparam logic [4:0] OPT_SUB   = 5'd1;
  localparam logic [4:0] OPT_SLL   = 5'd2;
  localparam logic [4:0] OPT_SLT   = 5'd3;
  localparam logic [4:0] OPT_SLTU  = 5'd4;
  localparam logic [4:0] OPT_XOR   = 5'd5;
  localparam logic [4:0] OPT_SRL   = 5'd6;
  localparam logic [4:0] OPT_SRA   = 5'd7;
  localparam logic [4:0] OPT_OR    = 5'd8;
  localparam logic [4:0] OPT_AND   = 5'd9;
  localparam logic [4:0] OPT_BEQ   = 5'd10;
  localparam logic [4:0] OPT_BNE   = 5'd11;
  localparam logic [4:0] OPT_BLT   = 5'd12;
  localparam logic [4:0] OPT_BGE   = 5'd13;
  localparam logic [4:0] OPT_BLTU  = 5'd14;
  localparam logic [4:0] OPT_BGEU  = 5'd15;
  localparam logic [4:0] OPT_CSRRW = 5'd16;
  localparam logic [4:0] OPT_CSRRS = 5'd17;
  localparam logic [4:0] OPT_CSRRC = 5'd18;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

endpackage

// File: rtl/csr_exec_unit_csr_regfile.sv
// rtl/csr_exec_unit_csr_regfile.sv - machine-mode CSR storage, ecall capture and read mux
// mscratch exists only when CSR_MSCRATCH_EN is defined.
module csr_regfile
  import csr_exec_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  input  logic            wr_en,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            ecall_en,
  input  logic [XLEN-1:0] ecall_pc,
  input  logic [XLEN-1:0] ecall_cause,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);

  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mcause;
`ifdef CSR_MSCRATCH_EN
  logic [XLEN-1:0] mscratch;
`endif

  // ecall is applied after the write decode so it overrides mepc/mcause writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus  <= MSTATUS_RST;
      mtvec    <= '0;
      mepc     <= '0;
      mcause   <= '0;
`ifdef CSR_MSCRATCH_EN
      mscratch <= '0;
`endif
    end else begin
      if (wr_en) begin
        case (wr_addr)
          CSR_MSTATUS:  mstatus  <= wr_data;
          CSR_MTVEC:    mtvec    <= wr_data;
          CSR_MEPC:     mepc     <= wr_data;
          CSR_MCAUSE:   mcause   <= wr_data;
`ifdef CSR_MSCRATCH_EN
          CSR_MSCRATCH: mscratch <= wr_data;
`endif
          default: ;
        endcase
      end
      if (ecall_en) begin
        mepc   <= ecall_pc;
        mcause <= ecall_cause;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CSR_MSTATUS:  rd_data = mstatus;
      CSR_MTVEC:    rd_data = mtvec;
      CSR_MEPC:     rd_data = mepc;
      CSR_MCAUSE:   rd_data = mcause;
`ifdef CSR_MSCRATCH_EN
      CSR_MSCRATCH: rd_data = mscratch;
`endif
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: rtl/csr_exec_unit.sv
// rtl/csr_exec_unit.sv - RV32 execute stage: reset-release flop, CSR file and combinational EXU
// Optional mscratch register via CSR_MSCRATCH_EN.
module csr_exec_unit
  import csr_exec_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  output logic            rst_sync,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_data_rs1,
  input  logic [XLEN-1:0] i_data_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic [4:0]      i_exu_opt_code,
  input  logic [2:0]      i_exu_sel_code,
  input  logic            i_ecall_en,
  input  logic [11:0]     i_addr_rd_csr,
  input  logic            i_wr_en_csr,
  input  logic [11:0]     i_addr_wr_csr,
  input  logic [XLEN-1:0] i_data_wr_csr,
  output logic [XLEN-1:0] o_exu_res,
  output logic [XLEN-1:0] o_csr_res,
  output logic            o_csr_res_en,
  output logic            o_zero,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc
);

  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) rst_sync <= 1'b1;
    else      rst_sync <= 1'b0;
  end

  csr_regfile u_csr_regfile (
    .clk         (clk),
    .rst         (rstn),
    .rd_addr     (i_addr_rd_csr),
    .rd_data     (csr_rdata),
    .wr_en       (i_wr_en_csr),
    .wr_addr     (i_addr_wr_csr),
    .wr_data     (i_data_wr_csr),
    .ecall_en    (i_ecall_en),
    .ecall_pc    (i_pc),
    .ecall_cause (i_data_rs1),
    .mtvec       (o_mtvec),
    .mepc        (o_mepc)
  );

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (i_exu_sel_code)
      SEL_RS1_RS2: begin op_a = i_data_rs1; op_b = i_data_rs2; end
      SEL_RS1_IMM: begin op_a = i_data_rs1; op_b = i_imm;      end
      SEL_PC_4:    begin op_a = i_pc;       op_b = 32'd4;      end
      SEL_PC_IMM:  begin op_a = i_pc;       op_b = i_imm;      end
      SEL_0_IMM:   begin op_a = '0;         op_b = i_imm;      end
      SEL_RS1_CSR: begin op_a = i_data_rs1; op_b = csr_rdata;  end
      default:     begin op_a = '0;         op_b = '0;         end
    endcase
  end

  assign shamt = op_b[4:0];

  // branch conditions always compare the raw register operands, not op_a/op_b
  always_comb begin
    o_exu_res    = '0;
    o_zero       = 1'b0;
    o_csr_res    = '0;
    o_csr_res_en = 1'b0;
    case (i_exu_opt_code)
      OPT_ADD:   o_exu_res = op_a + op_b;
      OPT_SUB:   o_exu_res = op_a - op_b;
      OPT_SLL:   o_exu_res = op_a << shamt;
      OPT_SLT:   o_exu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OPT_SLTU:  o_exu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OPT_XOR:   o_exu_res = op_a ^ op_b;
      OPT_SRL:   o_exu_res = op_a >> shamt;
      OPT_SRA:   o_exu_res = $unsigned($signed(op_a) >>> shamt);
      OPT_OR:    o_exu_res = op_a | op_b;
      OPT_AND:   o_exu_res = op_a & op_b;
      OPT_BEQ:   o_zero = (i_data_rs1 == i_data_rs2);
      OPT_BNE:   o_zero = (i_data_rs1 != i_data_rs2);
      OPT_BLT:   o_zero = ($signed(i_data_rs1) <  $signed(i_data_rs2));
      OPT_BGE:   o_zero = ($signed(i_data_rs1) >= $signed(i_data_rs2));
      OPT_BLTU:  o_zero = (i_data_rs1 <  i_data_rs2);
      OPT_BGEU:  o_zero = (i_data_rs1 >= i_data_rs2);
      OPT_CSRRW: begin
        o_exu_res    = csr_rdata;
        o_csr_res    = i_data_rs1;
        o_csr_res_en = 1'b1;
      end
      OPT_CSRRS: begin
        o_exu_res    = csr_rdata;
        o_csr_res    = csr_rdata | i_data_rs1;
        o_csr_res_en = 1'b1;
      end
      OPT_CSRRC: begin
        o_exu_res    = csr_rdata;
        o_csr_res    = csr_rdata & ~i_data_rs1;
        o_csr_res_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// tb/tb_csr_exec_unit.sv - self-checking bench for csr_exec_unit (honours CSR_MSCRATCH_EN)
module tb_csr_exec_unit;

  logic        clk;
  logic        rstn;
  logic        rst_sync;
  logic [31:0] i_pc, i_data_rs1, i_data_rs2, i_imm, i_data_wr_csr;
  logic [4:0]  i_exu_opt_code;
  logic [2:0]  i_exu_sel_code;
  logic        i_ecall_en, i_wr_en_csr;
  logic [11:0] i_addr_rd_csr, i_addr_wr_csr;
  logic [31:0] o_exu_res, o_csr_res, o_mtvec, o_mepc;
  logic        o_csr_res_en, o_zero;

  int tests = 0;
  int fails = 0;

  logic [31:0] csr_m [int];

  csr_exec_unit dut (
    .clk(clk), .rstn(rstn), .rst_sync(rst_sync),
    .i_pc(i_pc), .i_data_rs1(i_data_rs1), .i_data_rs2(i_data_rs2), .i_imm(i_imm),
    .i_exu_opt_code(i_exu_opt_code), .i_exu_sel_code(i_exu_sel_code),
    .i_ecall_en(i_ecall_en), .i_addr_rd_csr(i_addr_rd_csr),
    .i_wr_en_csr(i_wr_en_csr), .i_addr_wr_csr(i_addr_wr_csr), .i_data_wr_csr(i_data_wr_csr),
    .o_exu_res(o_exu_res), .o_csr_res(o_csr_res), .o_csr_res_en(o_csr_res_en),
    .o_zero(o_zero), .o_mtvec(o_mtvec), .o_mepc(o_mepc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic [4:0]  opt;
    logic [31:0] rs1, rs2, imm, pc;
    logic [11:0] rd_addr;
    logic [31:0] res;
    logic        zero;
    logic [31:0] csr_res;
    logic        en;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, int sel, int opt, logic [31:0] rs1, logic [31:0] rs2,
                              logic [31:0] imm, logic [31:0] pc, logic [11:0] ra,
                              logic [31:0] res, logic zero, logic [31:0] cr, logic en);
    vec_t v;
    v.name = n; v.sel = 3'(sel); v.opt = 5'(opt);
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc; v.rd_addr = ra;
    v.res = res; v.zero = zero; v.csr_res = cr; v.en = en;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic bit known_csr(int a);
`ifdef CSR_MSCRATCH_EN
    if (a == 'h340) return 1'b1;
`endif
    return (a == 'h300) || (a == 'h305) || (a == 'h341) || (a == 'h342);
  endfunction

  function automatic logic [31:0] csr_read(int a);
    if (known_csr(a) && csr_m.exists(a)) return csr_m[a];
    return 32'h0;
  endfunction

  task automatic model_reset();
    csr_m.delete();
    csr_m['h300] = 32'h0000_1800;
    csr_m['h305] = 0; csr_m['h341] = 0; csr_m['h342] = 0; csr_m['h340] = 0;
  endtask

  // reference EXU from the instruction semantics, using wide integer arithmetic
  task automatic exu_model(input int sel, input int opt, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] cv,
                           output logic [31:0] res, output logic zr, output logic [31:0] cr,
                           output logic en);
    logic [31:0] a, b;
    longint ua, ub, p2, q;
    int sa, sb, s;
    case (sel)
      0: begin a = rs1; b = rs2; end
      1: begin a = rs1; b = imm; end
      2: begin a = pc;  b = 4;   end
      3: begin a = pc;  b = imm; end
      4: begin a = 0;   b = imm; end
      5: begin a = rs1; b = cv;  end
      default: begin a = 0; b = 0; end
    endcase
    ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
    sa = int'(a); sb = int'(b);
    s = int'(ub % 32);
    p2 = longint'(1) << s;
    res = 0; zr = 1'b0; cr = 0; en = 1'b0;
    case (opt)
      0: res = 32'(ua + ub);
      1: res = 32'(ua - ub + 64'h1_0000_0000);
      2: res = 32'(ua * p2);
      3: res = (sa < sb) ? 1 : 0;
      4: res = (ua < ub) ? 1 : 0;
      5: res = a ^ b;
      6: res = 32'(ua / p2);
      7: begin
        q = longint'(sa) / p2;
        if (sa < 0 && (longint'(sa) % p2) != 0) q = q - 1;
        res = 32'(q);
      end
      8: res = a | b;
      9: res = a & b;
      10: zr = (rs1 == rs2);
      11: zr = (rs1 != rs2);
      12: zr = (int'(rs1) <  int'(rs2));
      13: zr = (int'(rs1) >= int'(rs2));
      14: zr = ({32'h0, rs1} <  {32'h0, rs2});
      15: zr = ({32'h0, rs1} >= {32'h0, rs2});
      16: begin res = cv; cr = rs1;        en = 1'b1; end
      17: begin res = cv; cr = cv | rs1;   en = 1'b1; end
      18: begin res = cv; cr = cv & ~rs1;  en = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    i_pc = 0; i_data_rs1 = 0; i_data_rs2 = 0; i_imm = 0; i_data_wr_csr = 0;
    i_exu_opt_code = 0; i_exu_sel_code = 0; i_ecall_en = 0; i_wr_en_csr = 0;
    i_addr_rd_csr = 0; i_addr_wr_csr = 0;
  endtask

  task automatic read_csr(input logic [11:0] a, output logic [31:0] v);
    i_addr_rd_csr = a; i_exu_opt_code = 5'd16; i_data_rs1 = 0;
    #1 v = o_exu_res;
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 6))
      0: return 12'h300;
      1: return 12'h305;
      2: return 12'h340;
      3: return 12'h341;
      4: return 12'h342;
      5: return 12'h7C0;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] v, e_res, e_cr;
    logic e_zero, e_en;
    logic [31:0] scratch_exp;

    idle_inputs();
    rstn = 1'b0;
    #1 rstn = 1'b1;
    #1 chk("rst_sync_async_set", {31'h0, rst_sync}, 32'h1);
    repeat (3) @(posedge clk);
    #1 chk("rst_sync_held", {31'h0, rst_sync}, 32'h1);
    @(negedge clk) rstn = 1'b0;
    #1 chk("rst_sync_through_release", {31'h0, rst_sync}, 32'h1);
    @(posedge clk);
    #1 chk("rst_sync_cleared", {31'h0, rst_sync}, 32'h0);
    model_reset();
    read_csr(12'h300, v); chk("reset_mstatus", v, 32'h0000_1800);
    read_csr(12'h305, v); chk("reset_mtvec_rd", v, 32'h0);
    read_csr(12'h342, v); chk("reset_mcause_rd", v, 32'h0);
    chk("reset_o_mtvec", o_mtvec, 32'h0);
    chk("reset_o_mepc", o_mepc, 32'h0);

    vecs.push_back(mk("add_wrap", 1, 0, 32'hFFFF_FFFF, 0, 1, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk("sra_neg", 1, 7, 32'h8000_0000, 0, 4, 0, 0, 32'hF800_0000, 0, 0, 0));
    vecs.push_back(mk("blt_taken", 0, 12, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk("bltu_not", 0, 14, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk("bge_not", 0, 13, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk("bgeu_taken", 0, 15, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk("csrrs_mstatus", 5, 17, 32'h8, 0, 0, 0, 12'h300, 32'h1800, 0, 32'h1808, 1));
    vecs.push_back(mk("csrrc_mstatus", 0, 18, 32'h800, 0, 0, 0, 12'h300, 32'h1800, 0, 32'h1000, 1));
    vecs.push_back(mk("csrrw_unknown", 0, 16, 32'hAB, 0, 0, 0, 12'h7C0, 32'h0, 0, 32'hAB, 1));
    vecs.push_back(mk("link_pc4", 2, 0, 0, 0, 0, 32'h100, 0, 32'h104, 0, 0, 0));
    vecs.push_back(mk("lui", 4, 0, 32'h55, 0, 32'h1234_5000, 0, 0, 32'h1234_5000, 0, 0, 0));
    vecs.push_back(mk("sub_neg", 0, 1, 5, 7, 0, 0, 0, 32'hFFFF_FFFE, 0, 0, 0));
    vecs.push_back(mk("opt_undef", 0, 20, 5, 7, 0, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk("sel_undef", 7, 8, 5, 7, 9, 9, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk("sll_b40", 1, 2, 32'h1, 0, 32'h24, 0, 0, 32'h10, 0, 0, 0));
    vecs.push_back(mk("add_csr_op", 5, 0, 32'h1, 0, 0, 0, 12'h300, 32'h1801, 0, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      i_exu_sel_code = vecs[k].sel; i_exu_opt_code = vecs[k].opt;
      i_data_rs1 = vecs[k].rs1; i_data_rs2 = vecs[k].rs2; i_imm = vecs[k].imm;
      i_pc = vecs[k].pc; i_addr_rd_csr = vecs[k].rd_addr;
      #1;
      chk({vecs[k].name, ".res"}, o_exu_res, vecs[k].res);
      chk({vecs[k].name, ".zero"}, {31'h0, o_zero}, {31'h0, vecs[k].zero});
      chk({vecs[k].name, ".csr_res"}, o_csr_res, vecs[k].csr_res);
      chk({vecs[k].name, ".csr_en"}, {31'h0, o_csr_res_en}, {31'h0, vecs[k].en});
    end

    // mtvec write then ecall
    @(negedge clk); idle_inputs();
    i_wr_en_csr = 1; i_addr_wr_csr = 12'h305; i_data_wr_csr = 32'h8000_0100;
    @(negedge clk); idle_inputs();
    i_ecall_en = 1; i_pc = 32'h8000_0040; i_data_rs1 = 11;
    @(negedge clk); idle_inputs();
    chk("ecall_mepc", o_mepc, 32'h8000_0040);
    chk("ecall_mtvec", o_mtvec, 32'h8000_0100);
    read_csr(12'h342, v); chk("ecall_mcause", v, 32'd11);

    // ecall beats a same-cycle mepc write
    @(negedge clk); idle_inputs();
    i_ecall_en = 1; i_pc = 32'h10; i_data_rs1 = 2;
    i_wr_en_csr = 1; i_addr_wr_csr = 12'h341; i_data_wr_csr = 32'h99;
    @(negedge clk); idle_inputs();
    chk("ecall_wins_mepc", o_mepc, 32'h10);

    // ecall does not block a same-cycle write to another CSR
    @(negedge clk); idle_inputs();
    i_ecall_en = 1; i_pc = 32'h20; i_data_rs1 = 3;
    i_wr_en_csr = 1; i_addr_wr_csr = 12'h305; i_data_wr_csr = 32'h200;
    @(negedge clk); idle_inputs();
    chk("ecall_plus_mtvec", o_mtvec, 32'h200);
    read_csr(12'h342, v); chk("ecall_plus_mcause", v, 32'd3);

    // mscratch behaviour depends on the build
    @(negedge clk); idle_inputs();
    i_wr_en_csr = 1; i_addr_wr_csr = 12'h340; i_data_wr_csr = 32'h55;
    @(negedge clk); idle_inputs();
`ifdef CSR_MSCRATCH_EN
    scratch_exp = 32'h55;
`else
    scratch_exp = 32'h0;
`endif
    read_csr(12'h340, v); chk("mscratch_rw", v, scratch_exp);

    // random traffic against the reference model
    model_reset();
    csr_m['h305] = 32'h200; csr_m['h341] = 32'h20; csr_m['h342] = 3;
    csr_m['h340] = scratch_exp;
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      i_exu_sel_code = 3'($urandom_range(0, 7));
      i_exu_opt_code = 5'($urandom_range(0, 21));
      i_data_rs1 = $urandom; i_data_rs2 = $urandom; i_imm = $urandom; i_pc = $urandom;
      if ($urandom_range(0, 3) == 0) i_data_rs2 = i_data_rs1;
      i_addr_rd_csr = pick_addr();
      i_wr_en_csr = 1'($urandom_range(0, 1));
      i_addr_wr_csr = pick_addr();
      i_data_wr_csr = $urandom;
      i_ecall_en = ($urandom_range(0, 3) == 0);
      #1;
      exu_model(int'(i_exu_sel_code), int'(i_exu_opt_code), i_data_rs1, i_data_rs2, i_imm, i_pc,
                csr_read(int'(i_addr_rd_csr)), e_res, e_zero, e_cr, e_en);
      chk("rnd.res", o_exu_res, e_res);
      chk("rnd.zero", {31'h0, o_zero}, {31'h0, e_zero});
      chk("rnd.csr_res", o_csr_res, e_cr);
      chk("rnd.csr_en", {31'h0, o_csr_res_en}, {31'h0, e_en});
      if (i_wr_en_csr && known_csr(int'(i_addr_wr_csr))) csr_m[int'(i_addr_wr_csr)] = i_data_wr_csr;
      if (i_ecall_en) begin
        csr_m['h341] = i_pc;
        csr_m['h342] = i_data_rs1;
      end
      @(negedge clk);
      chk("rnd.mtvec", o_mtvec, csr_read('h305));
      chk("rnd.mepc", o_mepc, csr_read('h341));
    end

    // asynchronous reset mid-cycle clears CSRs; EXU stays combinational
    idle_inputs();
    i_wr_en_csr = 1; i_addr_wr_csr = 12'h305; i_data_wr_csr = 32'hDEAD_0000;
    @(posedge clk); #2; idle_inputs();
    chk("pre_reset_mtvec", o_mtvec, 32'hDEAD_0000);
    rstn = 1'b1;
    #1;
    chk("midrst_mtvec", o_mtvec, 32'h0);
    chk("midrst_mepc", o_mepc, 32'h0);
    chk("midrst_rst_sync", {31'h0, rst_sync}, 32'h1);
    read_csr(12'h300, v); chk("midrst_mstatus", v, 32'h0000_1800);
    i_exu_opt_code = 5'd5; i_exu_sel_code = 3'd0; i_data_rs1 = 32'hF0F0; i_data_rs2 = 32'h0FF0;
    #1 chk("midrst_exu_xor", o_exu_res, 32'hFF00);
    @(negedge clk) rstn = 1'b0;
    @(posedge clk); #1 chk("midrst_release", {31'h0, rst_sync}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csr_exec_unit.md
Name: csr_exec_unit

Overview:
- Combined execute stage for the single-cycle RV32 core.
- Contains a reset-release register, a machine-mode CSR file (mstatus/mtvec/mepc/mcause) with ecall/mret support, and the combinational EXU (ALU, branch compare, CSR read-modify).
- Sits between IDU/GPR and LSU/WBU; feeds the PCU trap targets.

Parameters:
- XLEN, 32, datapath width.
- MSTATUS_RST, 32'h0000_1800, mstatus reset value (MPP=M).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-high reset (asserted = 1).
- rst_sync  out  1  registered reset for downstream blocks. Asserts immediately with rstn; deasserts on the first clk edge after rstn falls.
- i_pc  in  XLEN  current PC.
- i_data_rs1  in  XLEN  rs1 value; also the ecall cause number.
- i_data_rs2  in  XLEN  rs2 value.
- i_imm  in  XLEN  sign-extended immediate.
- i_exu_opt_code  in  5  operation select.
- i_exu_sel_code  in  3  operand select.
- i_ecall_en  in  1  ecall in this cycle.
- i_addr_rd_csr  in  12  CSR read address.
- i_wr_en_csr  in  1  CSR write enable.
- i_addr_wr_csr  in  12  CSR write address.
- i_data_wr_csr  in  XLEN  CSR write data.
- o_exu_res  out  XLEN  ALU result / rd value / LSU address.
- o_csr_res  out  XLEN  new CSR value.
- o_csr_res_en  out  1  CSR op active.
- o_zero  out  1  branch condition true.
- o_mtvec  out  XLEN  mtvec contents.
- o_mepc  out  XLEN  mepc contents.

Behaviour:
- rst_sync flop: async set by rstn; synchronous clear one cycle after rstn drops.
- CSR file is reset by rstn (asynchronous).
  - Reset values: mstatus = MSTATUS_RST; mtvec, mepc, mcause = 0.
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
- CSR read is combinational at i_addr_rd_csr. Unknown address reads 0.
- CSR write: on clk edge when i_wr_en_csr = 1 to a known address. Writes to unknown addresses are ignored.
- ecall (i_ecall_en = 1) at clk edge: mepc <= i_pc, mcause <= i_data_rs1.
  - If a CSR write in the same cycle targets mepc or mcause, the ecall wins.
  - Same-cycle writes to other CSRs still occur.
- o_mtvec and o_mepc are direct register outputs; mret needs no internal state change.
- Operand select (i_exu_sel_code):
  - 0: A = rs1, B = rs2.
  - 1: A = rs1, B = imm.
  - 2: A = pc, B = 4 (link).
  - 3: A = pc, B = imm (auipc).
  - 4: A = 0, B = imm (lui).
  - 5: A = rs1, B = csr_rdata.
  - Other codes: A = B = 0.
- Operations (i_exu_opt_code), all combinational, 32-bit wrap:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND. Shifts use B[4:0].
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
  - 16 CSRRW, 17 CSRRS, 18 CSRRC.
  - Undefined codes: result 0.
- Branch ops (10–15):
  - o_zero = condition on (rs1, rs2); o_exu_res = 0.
  - o_zero = 0 for all non-branch ops.
- CSR ops (16–18):
  - o_exu_res = csr_rdata (old value).
  - o_csr_res = rs1 (W), csr_rdata | rs1 (S), csr_rdata & ~rs1 (C).
  - o_csr_res_en = 1; 0 for all other ops.
- o_csr_res = 0 when o_csr_res_en = 0.
- Mid-operation reset: all CSRs return to reset values asynchronously; the EXU is stateless and unaffected.

Optional Feature:
- Macro CSR_MSCRATCH_EN.
- Defined: adds mscratch at 0x340 (reset 0), readable and writable like the other CSRs.
- Undefined: 0x340 reads 0 and writes are ignored.

Decomposition:
- Shared package holds:
  - XLEN;
  - opt/sel code localparams;
  - CSR address constants;
  - MSTATUS_RST.
- One natural sub-module: csr_regfile, containing the CSR storage, ecall update and read mux.
- Reset flop and EXU logic live in the top.

Test Plan:
- Assert rstn 3 cycles, release -> rst_sync high through release, low after next edge. Read 0x300 -> 0x1800; mtvec/mepc read 0.
- sel=1, opt=0, rs1=0xFFFFFFFF, imm=1 -> exu_res=0. opt=7 SRA, rs1=0x80000000, imm=4 -> 0xF8000000.
- opt=12 BLT, rs1=-1, rs2=1 -> zero=1. opt=14 BLTU with the same operands -> zero=0.
- mtvec=0x80000100 via write; then ecall with pc=0x80000040, rs1=11 -> mepc=0x80000040, mcause=11, o_mtvec=0x80000100.
- CSRRS on 0x300 with rs1=0x8 -> exu_res=0x1800, csr_res=0x1808, csr_res_en=1.
- Same-cycle ecall (pc=0x10) and CSR write mepc=0x99 -> mepc=0x10.
